// File: rtl/seq_arith_pkg.sv
// Shared op-codes, FSM state type and latency helpers for the sequential arithmetic unit.
package seq_arith_pkg;

  localparam logic [1:0] OP_MUL   = 2'd0;
  localparam logic [1:0] OP_SQR   = 2'd1;
  localparam logic [1:0] OP_ISQRT = 2'd2;
  localparam logic [1:0] OP_GMEAN = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_SQRT
  } state_t;

  function automatic int unsigned lat_mul(input int unsigned w);
    return w;
  endfunction

  function automatic int unsigned lat_isqrt(input int unsigned w);
    return w / 2;
  endfunction

  function automatic int unsigned lat_gmean(input int unsigned w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/isqrt_step.sv
// One restoring bit-pair square-root iteration: shift in the next radicand pair and
// try to subtract (4*root + 1).
module isqrt_step #(
  parameter int N = 32
) (
  input  logic [N-1:0]   rem,
  input  logic [N/2-1:0] root,
  input  logic [1:0]     pair,
  output logic [N-1:0]   next_rem,
  output logic [N/2-1:0] next_root
);

  localparam int H = N / 2;

  logic [N+1:0] rem_sh;
  logic [N+1:0] trial;
  logic         ge;

  // Widened by two bits so the shifted remainder never loses its top bits.
  assign rem_sh    = {rem, pair};
  assign trial     = (N + 2)'({root, 2'b01});
  assign ge        = (rem_sh >= trial);
  assign next_rem  = ge ? N'(rem_sh - trial) : N'(rem_sh);
  assign next_root = H'({root, ge});

endmodule

// File: rtl/seq_arith_unit.sv
// Iterative MUL / SQR / ISQRT / GMEAN unit: shift-add multiplier feeding a shared
// bit-pair square-root step, with a single start/busy/done handshake.
module seq_arith_unit
  import seq_arith_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [1:0]     op_bi,
  input  logic [W-1:0]   a_bi,
  input  logic [W-1:0]   b_bi,
  output logic           busy_o,
  output logic           done_o,
  output logic [2*W-1:0] y_bo
);

  localparam int CNT_W = $clog2(W) + 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [2*W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [2*W-1:0]   rad_q, rad_d;
  logic [2*W-1:0]   rem_q, rem_d;
  logic [W-1:0]     root_q, root_d;
  logic             done_q, done_d;
  logic [2*W-1:0]   y_q, y_d;

  logic [2*W-1:0]   acc_sum;
  logic [2*W-1:0]   step_rem;
  logic [W-1:0]     step_root;

  isqrt_step #(.N(2 * W)) u_step (
    .rem       (rem_q),
    .root      (root_q),
    .pair      (rad_q[2*W-1 -: 2]),
    .next_rem  (step_rem),
    .next_root (step_root)
  );

  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      rad_q    <= '0;
      rem_q    <= '0;
      root_q   <= '0;
      done_q   <= 1'b0;
      y_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      rad_q    <= rad_d;
      rem_q    <= rem_d;
      root_q   <= root_d;
      done_q   <= done_d;
      y_q      <= y_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    rad_d    = rad_q;
    rem_d    = rem_q;
    root_d   = root_q;
    done_d   = 1'b0;
    y_d      = y_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          op_d     = op_bi;
          mcand_d  = {{W{1'b0}}, a_bi};
          mplier_d = (op_bi == OP_SQR) ? a_bi : b_bi;
          acc_d    = '0;
          rem_d    = '0;
          root_d   = '0;
          if (op_bi == OP_ISQRT) begin
            // A W-bit radicand is top-aligned so the pair taps stay fixed.
            state_d = ST_SQRT;
            rad_d   = {a_bi, {W{1'b0}}};
            cnt_d   = CNT_W'(lat_isqrt(W) - 1);
          end else begin
            state_d = ST_MUL;
            rad_d   = '0;
            cnt_d   = CNT_W'(lat_mul(W) - 1);
          end
        end
      end
      ST_MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          if (op_q == OP_GMEAN) begin
            state_d = ST_SQRT;
            rad_d   = acc_sum;
            cnt_d   = CNT_W'(W - 1);
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            y_d     = acc_sum;
          end
        end
      end
      ST_SQRT: begin
        rad_d  = rad_q << 2;
        rem_d  = step_rem;
        root_d = step_root;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          y_d     = {{W{1'b0}}, step_root};
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = done_q;
  assign y_bo   = y_q;

endmodule

// File: tb/tb_seq_arith_unit.sv
// Self-checking bench for seq_arith_unit: per-cycle comparison against a latency/result
// model, literal spot checks, then randomized operations with ignored mid-op requests.
module tb_seq_arith_unit;

  localparam int W = 16;

  logic           clk_i   = 1'b0;
  logic           rst_i   = 1'b0;
  logic           start_i = 1'b0;
  logic [1:0]     op_bi   = '0;
  logic [W-1:0]   a_bi    = '0;
  logic [W-1:0]   b_bi    = '0;
  logic           busy_o;
  logic           done_o;
  logic [2*W-1:0] y_bo;

  int total = 0;
  int bad   = 0;
  longint unsigned cyc = 0;
  longint unsigned acc_cyc = 0;

  seq_arith_unit #(.W(W)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .op_bi   (op_bi),
    .a_bi    (a_bi),
    .b_bi    (b_bi),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .y_bo    (y_bo)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic longint unsigned isqrt64(input longint unsigned x);
    longint unsigned r = 0;
    longint unsigned c;
    for (int i = 31; i >= 0; i--) begin
      c = r | (64'd1 << i);
      if (c * c <= x) r = c;
    end
    return r;
  endfunction

  function automatic longint unsigned ref_res(input logic [1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    longint unsigned la = 64'(a);
    longint unsigned lb = 64'(b);
    case (op)
      2'd0:    return la * lb;
      2'd1:    return la * la;
      2'd2:    return isqrt64(la);
      default: return isqrt64(la * lb);
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op);
    case (op)
      2'd2:    return W / 2;
      2'd3:    return 2 * W;
      default: return W;
    endcase
  endfunction

  // Model: an accepted request completes a fixed number of edges later.
  logic           m_busy = 1'b0;
  logic           m_done = 1'b0;
  logic [2*W-1:0] m_y    = '0;
  logic [2*W-1:0] m_res  = '0;
  int             m_left = 0;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_y    <= '0;
      m_res  <= '0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_y    <= m_res;
        end
        m_left <= m_left - 1;
      end else if (start_i) begin
        m_busy <= 1'b1;
        m_left <= ref_lat(op_bi);
        m_res  <= (2 * W)'(ref_res(op_bi, a_bi, b_bi));
      end
    end
  end

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    chk("busy_o", 64'(busy_o), 64'(m_busy));
    chk("done_o", 64'(done_o), 64'(m_done));
    chk("y_bo",   64'(y_bo),   64'(m_y));
  end

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    op_bi   = op;
    a_bi    = a;
    b_bi    = b;
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done(input string name, input longint unsigned exp_y, input int exp_lat);
    int n = 0;
    while (!done_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    if (!done_o) begin
      chk({name, " timeout"}, 0, 1);
    end else begin
      chk({name, " latency"}, cyc - acc_cyc, 64'(exp_lat));
      chk({name, " result"}, 64'(y_bo), exp_y);
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]   op;
    logic [W-1:0] a, b;

    repeat (3) @(negedge clk_i);
    chk("reset busy", 64'(busy_o), 0);
    chk("reset done", 64'(done_o), 0);
    chk("reset y",    64'(y_bo),   0);
    rst_i = 1'b1;
    @(negedge clk_i);

    issue(2'd0, 16'd300, 16'd200);
    chk("busy after accept", 64'(busy_o), 1);
    wait_done("mul 300*200", 60000, 16);
    issue(2'd1, 16'hFFFF, 16'd0);
    wait_done("sqr ffff", 64'hFFFE0001, 16);
    issue(2'd2, 16'hFFFF, 16'd0);
    wait_done("isqrt ffff", 255, 8);
    issue(2'd3, 16'd50, 16'd2);
    wait_done("gmean 50,2", 10, 32);
    issue(2'd3, 16'hFFFF, 16'hFFFF);
    wait_done("gmean ffff,ffff", 64'hFFFF, 32);

    // Request during MUL must be dropped, then a back-to-back start in the done cycle.
    issue(2'd0, 16'd300, 16'd200);
    repeat (4) @(negedge clk_i);
    op_bi = 2'd2; a_bi = 16'd81; start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    wait_done("mul with ignored start", 60000, 16);
    issue(2'd2, 16'd81, 16'd0);
    wait_done("b2b isqrt 81", 9, 8);

    // Asynchronous reset part-way through a GMEAN.
    issue(2'd3, 16'd50, 16'd2);
    repeat (4) @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    chk("abort busy", 64'(busy_o), 0);
    chk("abort done", 64'(done_o), 0);
    chk("abort y",    64'(y_bo),   0);
    repeat (2) @(negedge clk_i);
    #2 rst_i = 1'b1;
    @(negedge clk_i);
    issue(2'd0, 16'd0, 16'd7);
    wait_done("mul 0*7", 0, 16);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick_operand();
      b  = pick_operand();
      issue(op, a, b);
      op_bi = 2'($urandom);
      a_bi  = W'($urandom);
      b_bi  = W'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        repeat (2) @(negedge clk_i);
        start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
      end
      wait_done("random op", ref_res(op, a, b), ref_lat(op));
    end

    repeat (3) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
